// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, transmitter FSM states and baud arithmetic.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  // Clocks per bit; integer division truncates.
  function automatic int unsigned bps_cnt(input int unsigned clk_freq, input int unsigned bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_send_if.sv
// Byte-side valid/ready handshake of the UART transmitter.
interface uart_send_if;
  import uart_pkg::*;

  logic                   tx_valid;
  logic                   tx_ready;
  logic [UART_DATA_W-1:0] tx_data;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Per-bit cycle counter: counts 0..BPS_CNT-1 and flags the last and second-to-last cycle of a bit.
module uart_baud_tick #(
  parameter int unsigned BPS_CNT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end,
  output logic pre_end
);

  logic [15:0] clk_cnt_q, clk_cnt_d;

  assign bit_end = (clk_cnt_q == 16'(BPS_CNT - 1));
  // Lets registered outputs land exactly on the last cycle of a bit.
  assign pre_end = (clk_cnt_q == 16'(BPS_CNT - 2));

  always_comb begin
    clk_cnt_d = clk_cnt_q + 16'd1;
    if (clear || bit_end) begin
      clk_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt_q <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
    end
  end

endmodule

// File: rtl/uart_send.sv
// UART transmitter: 8N1/8N2 frames, LSB first, with a one-entry holding buffer so that
// back-to-back bytes go out without an idle gap.
module uart_send
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned UART_BPS  = 115200,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  uart_send_if.slave tx_bus,
  output logic       uart_txd,
  output logic       uart_busy,
  output logic       tx_done
);

  localparam int unsigned BPS_CNT   = bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic        STOP_LAST = (STOP_BITS == 2);

  if (BPS_CNT < 2 || BPS_CNT > 65535) begin : g_bad_bps
    $error("uart_send: BPS_CNT must be within 2..65535");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_send: STOP_BITS must be 1 or 2");
  end

  tx_state_e              state_q, state_d;
  logic                   buf_full_q, buf_full_d;
  logic [UART_DATA_W-1:0] buf_data_q, buf_data_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   txd_q, txd_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   accept, unload, last_stop;
  logic                   bit_end, pre_end;

  uart_baud_tick #(
    .BPS_CNT(BPS_CNT)
  ) u_baud_tick (
    .clk    (sys_clk),
    .rst    (sys_rst_n),
    .clear  (state_q == StIdle),
    .bit_end(bit_end),
    .pre_end(pre_end)
  );

  assign accept    = tx_bus.tx_valid & ready_q;
  assign last_stop = (stop_cnt_q == STOP_LAST);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    txd_d      = txd_q;
    done_d     = 1'b0;
    unload     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (buf_full_q) begin
          state_d = StStart;
          shift_d = buf_data_q;
          unload  = 1'b1;
          txd_d   = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_cnt_d = '0;
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
            state_d    = StStop;
            stop_cnt_d = 1'b0;
            txd_d      = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      StStop: begin
        done_d = pre_end & last_stop;
        if (bit_end) begin
          if (!last_stop) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end else if (buf_full_q) begin
            // Chain straight into the next start bit.
            state_d = StStart;
            shift_d = buf_data_q;
            unload  = 1'b1;
            txd_d   = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    buf_full_d = accept | (buf_full_q & ~unload);
    buf_data_d = accept ? tx_bus.tx_data : buf_data_q;
    ready_d    = ~buf_full_d;
    busy_d     = (state_d != StIdle) | buf_full_d;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      state_q    <= StIdle;
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_bus.tx_ready = ready_q;
  assign uart_txd        = txd_q;
  assign uart_busy       = busy_q;
  assign tx_done         = done_q;

endmodule

// File: tb/tb_uart_send.sv
// Self-checking bench for uart_send: table-driven frames, multi-cycle corner sequences and a
// randomized phase decoded by a line monitor against a byte queue.
module tb_uart_send;

  localparam int unsigned CF      = 1000;
  localparam int unsigned BPS     = 100;
  localparam int          BIT_CYC = 10;
  localparam int          NRAND   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd1, busy1, done1;
  logic txd2, busy2, done2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // bit i = i-th bit on the wire (start .. stop)
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] sb[$];

  uart_send_if bus1();
  uart_send_if bus2();

  uart_send #(
    .CLK_FREQ (CF),
    .UART_BPS (BPS),
    .STOP_BITS(1)
  ) dut1 (
    .sys_clk  (clk),
    .sys_rst_n(rst),
    .tx_bus   (bus1),
    .uart_txd (txd1),
    .uart_busy(busy1),
    .tx_done  (done1)
  );

  uart_send #(
    .CLK_FREQ (CF),
    .UART_BPS (BPS),
    .STOP_BITS(2)
  ) dut2 (
    .sys_clk  (clk),
    .sys_rst_n(rst),
    .tx_bus   (bus2),
    .uart_txd (txd2),
    .uart_busy(busy2),
    .tx_done  (done2)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [9:0] frame_bits(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  function automatic logic txd_of(input int w);
    return (w == 2) ? txd2 : txd1;
  endfunction

  function automatic logic done_of(input int w);
    return (w == 2) ? done2 : done1;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 2) ? busy2 : busy1;
  endfunction

  function automatic logic rdy_of(input int w);
    return (w == 2) ? bus2.tx_ready : bus1.tx_ready;
  endfunction

  // Call at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send(input int w, input logic [7:0] b);
    int n;
    n = 0;
    while (rdy_of(w) !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_timeout", 32'(n >= 1000), 0);
    if (w == 2) begin
      bus2.tx_valid = 1'b1;
      bus2.tx_data  = b;
    end else begin
      bus1.tx_valid = 1'b1;
      bus1.tx_data  = b;
    end
    @(negedge clk);
    bus1.tx_valid = 1'b0;
    bus2.tx_valid = 1'b0;
  endtask

  // Starts from the cycle after acceptance; first negedge is the start bit.
  task automatic check_frame(input int w, input logic [9:0] line, input int stops);
    int len;
    int idx;
    len = (9 + stops) * BIT_CYC;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      idx = k / BIT_CYC;
      chk("frame_txd", 32'(txd_of(w)), 32'((idx < 10) ? line[idx] : 1'b1));
      chk("frame_done", 32'(done_of(w)), 32'(k == len - 1));
      chk("frame_busy", 32'(busy_of(w)), 1);
    end
  endtask

  task automatic idle_check(input int w);
    @(negedge clk);
    chk("idle_txd", 32'(txd_of(w)), 1);
    chk("idle_busy", 32'(busy_of(w)), 0);
    chk("idle_ready", 32'(rdy_of(w)), 1);
    chk("idle_done", 32'(done_of(w)), 0);
  endtask

  initial begin
    logic [29:0] line3;
    logic [7:0]  got;
    logic [7:0]  rb;
    int          n;

    vecs[0] = '{data: 8'h55, line: 10'h2AA};
    vecs[1] = '{data: 8'hA5, line: 10'h34A};
    vecs[2] = '{data: 8'h00, line: 10'h200};
    vecs[3] = '{data: 8'hFF, line: 10'h3FE};

    bus1.tx_valid = 1'b0;
    bus1.tx_data  = '0;
    bus2.tx_valid = 1'b0;
    bus2.tx_data  = '0;

    // Reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_check(1);
    idle_check(2);

    // Table-driven single frames
    for (int i = 0; i < 4; i++) begin
      send(1, vecs[i].data);
      chk("accept_txd_high", 32'(txd1), 1);
      chk("accept_ready_low", 32'(bus1.tx_ready), 0);
      chk("accept_busy", 32'(busy1), 1);
      check_frame(1, vecs[i].line, 1);
      idle_check(1);
    end

    // Back-to-back frames, plus a byte held while the buffer is full
    line3 = {frame_bits(8'h11), frame_bits(8'h3C), frame_bits(8'hA5)};
    send(1, 8'hA5);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == 32) begin
        bus1.tx_valid = 1'b1;
        bus1.tx_data  = 8'h3C;
      end
      if (k == 33) bus1.tx_valid = 1'b0;
      if (k == 40) begin
        bus1.tx_valid = 1'b1;
        bus1.tx_data  = 8'h11;
      end
      if (k == 101) bus1.tx_valid = 1'b0;
      chk("b2b_txd", 32'(txd1), 32'(line3[k/BIT_CYC]));
      chk("b2b_done", 32'(done1), 32'(k == 99 || k == 199 || k == 299));
      chk("b2b_busy", 32'(busy1), 1);
      if (k > 40 && k < 100) chk("hold_ready_low", 32'(bus1.tx_ready), 0);
      if (k == 100) chk("hold_ready_after_unload", 32'(bus1.tx_ready), 1);
      if (k == 101) chk("hold_ready_refilled", 32'(bus1.tx_ready), 0);
    end
    idle_check(1);

    // Reset in the middle of data bit 4
    send(1, 8'hF0);
    repeat (55) @(negedge clk);
    chk("pre_reset_bit4", 32'(txd1), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_txd", 32'(txd1), 1);
    chk("reset_ready", 32'(bus1.tx_ready), 1);
    chk("reset_busy", 32'(busy1), 0);
    chk("reset_done", 32'(done1), 0);
    rst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      chk("post_reset_no_done", 32'(done1), 0);
      chk("post_reset_line", 32'(txd1), 1);
    end
    send(1, 8'h0F);
    check_frame(1, frame_bits(8'h0F), 1);
    idle_check(1);

    // Two stop bits
    send(2, 8'h80);
    check_frame(2, 10'h300, 2);
    idle_check(2);

    // Randomized bytes and gaps, decoded from the line
    fork
      begin : sender
        for (int i = 0; i < NRAND; i++) begin
          rb = 8'($urandom);
          repeat ($urandom_range(0, 150)) @(negedge clk);
          sb.push_back(rb);
          send(1, rb);
        end
      end
      begin : monitor
        for (int f = 0; f < NRAND; f++) begin
          n = 0;
          do begin
            @(negedge clk);
            n++;
          end while (txd1 !== 1'b0 && n < 5000);
          chk("rand_start_timeout", 32'(n >= 5000), 0);
          if (n >= 5000) break;
          got = '0;
          for (int k = 1; k < 100; k++) begin
            @(negedge clk);
            if (k == 5) chk("rand_start_mid", 32'(txd1), 0);
            if (k % BIT_CYC == 5 && k >= 15 && k <= 85) got[k/BIT_CYC-1] = txd1;
            if (k == 95) chk("rand_stop_mid", 32'(txd1), 1);
            chk("rand_done", 32'(done1), 32'(k == 99));
          end
          chk("rand_queue_empty", 32'(sb.size() == 0), 0);
          if (sb.size() != 0) chk("rand_byte", 32'(got), 32'(sb.pop_front()));
        end
      end
    join
    chk("rand_queue_drained", 32'(sb.size()), 0);
    idle_check(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
